// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures trap/mret at WB, emits a trap record,
// flushes, waits for CSR-side targets to settle, then issues a held redirect.
module trap_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic        wb_exc_valid_i,
  input  logic [30:0] wb_exc_cause_i,
  input  logic [31:0] wb_exc_tval_i,
  input  logic        wb_mret_i,
  input  logic        irq_i,
  input  logic        irq_en_i,
  input  logic [31:0] trap_handler_addr_i,
  input  logic [31:0] mepc_i,
  input  logic        redirect_ready_i,
  output logic        trap_valid_o,
  output logic        trap_is_interrupt_o,
  output logic [30:0] trap_mcause_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_tval_o,
  output logic        wb_kill_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, REDIRECT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       tgt_mepc;
  logic       irq_take, det_irq, det_exc, det_mret, det_trap, det_any;
  logic       settle_done;

  // Priority: interrupt > exception > mret, only on a valid WB slot in IDLE.
  assign irq_take    = irq_i & irq_en_i;
  assign det_irq     = (state == IDLE) & wb_valid_i & irq_take;
  assign det_exc     = (state == IDLE) & wb_valid_i & wb_exc_valid_i & ~irq_take;
  assign det_mret    = (state == IDLE) & wb_valid_i & wb_mret_i & ~wb_exc_valid_i & ~irq_take;
  assign det_trap    = det_irq | det_exc;
  assign det_any     = det_trap | det_mret;
  assign settle_done = (state == SETTLE) && (cnt == 4'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (det_any) state_nxt = SETTLE;
      SETTLE:   if (settle_done) state_nxt = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_kill_o        = det_trap;
    flush_o          = (state != IDLE);
    redirect_valid_o = (state == REDIRECT);
  end

  // Counter hits 0 on the cycle the target is sampled into redirect_pc_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt           <= 4'd0;
      tgt_mepc      <= 1'b0;
      redirect_pc_o <= 32'd0;
    end else begin
      if (det_any) begin
        cnt      <= 4'(SETTLE_CYCLES);
        tgt_mepc <= det_mret;
      end else if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
      end
      if (settle_done)
        redirect_pc_o <= tgt_mepc ? mepc_i : (trap_handler_addr_i & 32'hffff_fffc);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_valid_o        <= 1'b0;
      trap_is_interrupt_o <= 1'b0;
      trap_mcause_o       <= 31'd0;
      trap_pc_o           <= 32'd0;
      trap_tval_o         <= 32'd0;
    end else begin
      trap_valid_o <= det_trap;
      if (det_trap) begin
        trap_is_interrupt_o <= det_irq;
        trap_mcause_o       <= det_irq ? 31'd11 : wb_exc_cause_i;
        trap_pc_o           <= wb_pc_i;
        trap_tval_o         <= det_irq ? 32'd0 : wb_exc_tval_i;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed expectations per cycle.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i, wb_exc_valid_i, wb_mret_i, irq_i, irq_en_i, redirect_ready_i;
  logic [31:0] wb_pc_i, wb_exc_tval_i, trap_handler_addr_i, mepc_i;
  logic [30:0] wb_exc_cause_i;
  logic        trap_valid_o, trap_is_interrupt_o, wb_kill_o, flush_o, redirect_valid_o;
  logic [30:0] trap_mcause_o;
  logic [31:0] trap_pc_o, trap_tval_o, redirect_pc_o;

  int checks = 0;
  int failures = 0;

  trap_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_exc_valid_i(wb_exc_valid_i), .wb_exc_cause_i(wb_exc_cause_i),
    .wb_exc_tval_i(wb_exc_tval_i), .wb_mret_i(wb_mret_i),
    .irq_i(irq_i), .irq_en_i(irq_en_i),
    .trap_handler_addr_i(trap_handler_addr_i), .mepc_i(mepc_i),
    .redirect_ready_i(redirect_ready_i),
    .trap_valid_o(trap_valid_o), .trap_is_interrupt_o(trap_is_interrupt_o),
    .trap_mcause_o(trap_mcause_o), .trap_pc_o(trap_pc_o), .trap_tval_o(trap_tval_o),
    .wb_kill_o(wb_kill_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_wb();
    wb_valid_i = 0; wb_exc_valid_i = 0; wb_mret_i = 0; irq_i = 0;
    wb_pc_i = 0; wb_exc_cause_i = 0; wb_exc_tval_i = 0;
  endtask

  task automatic exc_evt(input logic [31:0] pc, input logic [30:0] cause, input logic [31:0] tval);
    wb_valid_i = 1; wb_exc_valid_i = 1; wb_pc_i = pc; wb_exc_cause_i = cause; wb_exc_tval_i = tval;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tv"}, 32'(trap_valid_o), 0);
    chk({tag, ".ti"}, 32'(trap_is_interrupt_o), 0);
    chk({tag, ".mc"}, 32'(trap_mcause_o), 0);
    chk({tag, ".pc"}, trap_pc_o, 0);
    chk({tag, ".tval"}, trap_tval_o, 0);
    chk({tag, ".fl"}, 32'(flush_o), 0);
    chk({tag, ".rv"}, 32'(redirect_valid_o), 0);
    chk({tag, ".rpc"}, redirect_pc_o, 0);
  endtask

  initial begin
    clr_wb();
    irq_en_i = 0; redirect_ready_i = 1;
    trap_handler_addr_i = 32'h8000_0004; mepc_i = 0;
    rst_i = 1;
    #1;
    chk_zero("rst");
    tick(); tick();
    rst_i = 0;
    tick();

    // Exception with ready high.
    exc_evt(32'h100, 31'd2, 32'hDEAD);
    #1;
    chk("exc.kill", 32'(wb_kill_o), 1);
    chk("exc.fl0", 32'(flush_o), 0);
    tick(); clr_wb();                                   // N+1
    chk("exc.tv", 32'(trap_valid_o), 1);
    chk("exc.ti", 32'(trap_is_interrupt_o), 0);
    chk("exc.mc", 32'(trap_mcause_o), 2);
    chk("exc.pc", trap_pc_o, 32'h100);
    chk("exc.tval", trap_tval_o, 32'hDEAD);
    chk("exc.fl1", 32'(flush_o), 1);
    chk("exc.rv1", 32'(redirect_valid_o), 0);
    tick();                                             // N+2
    chk("exc.tv2", 32'(trap_valid_o), 0);
    chk("exc.mchold", 32'(trap_mcause_o), 2);
    chk("exc.rv2", 32'(redirect_valid_o), 0);
    chk("exc.fl2", 32'(flush_o), 1);
    tick();                                             // N+3
    chk("exc.rv3", 32'(redirect_valid_o), 1);
    chk("exc.rpc", redirect_pc_o, 32'h8000_0004);
    chk("exc.fl3", 32'(flush_o), 1);
    tick();                                             // N+4
    chk("exc.rv4", 32'(redirect_valid_o), 0);
    chk("exc.fl4", 32'(flush_o), 0);

    // Interrupt beats a simultaneous exception.
    irq_en_i = 1; irq_i = 1;
    exc_evt(32'h300, 31'd5, 32'h77);
    #1;
    chk("irq.kill", 32'(wb_kill_o), 1);
    tick(); clr_wb();
    chk("irq.tv", 32'(trap_valid_o), 1);
    chk("irq.ti", 32'(trap_is_interrupt_o), 1);
    chk("irq.mc", 32'(trap_mcause_o), 11);
    chk("irq.pc", trap_pc_o, 32'h300);
    chk("irq.tval", trap_tval_o, 0);
    tick(); tick(); tick();

    // Interrupts disabled: exception record instead.
    irq_en_i = 0; irq_i = 1;
    exc_evt(32'h304, 31'd7, 32'h55);
    tick(); clr_wb();
    chk("irqdis.ti", 32'(trap_is_interrupt_o), 0);
    chk("irqdis.mc", 32'(trap_mcause_o), 7);
    chk("irqdis.tval", trap_tval_o, 32'h55);
    tick(); tick(); tick();

    // mret: no record, retires, redirect to mepc.
    mepc_i = 32'h200;
    wb_valid_i = 1; wb_mret_i = 1; wb_pc_i = 32'h400;
    #1;
    chk("mret.kill", 32'(wb_kill_o), 0);
    tick(); clr_wb();
    chk("mret.tv", 32'(trap_valid_o), 0);
    chk("mret.fl", 32'(flush_o), 1);
    tick(); tick();
    chk("mret.rv", 32'(redirect_valid_o), 1);
    chk("mret.rpc", redirect_pc_o, 32'h200);
    tick();
    chk("mret.fl4", 32'(flush_o), 0);

    // Backpressure with an exception presented during the wait.
    redirect_ready_i = 0;
    trap_handler_addr_i = 32'h0000_0a00;
    exc_evt(32'h500, 31'd4, 32'h1);
    tick(); clr_wb(); tick(); tick();                   // N+3
    exc_evt(32'h600, 31'd9, 32'h2);
    trap_handler_addr_i = 32'h0000_0b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp.kill%0d", i), 32'(wb_kill_o), 0);
      chk($sformatf("bp.rv%0d", i), 32'(redirect_valid_o), 1);
      chk($sformatf("bp.rpc%0d", i), redirect_pc_o, 32'h0000_0a00);
      chk($sformatf("bp.tv%0d", i), 32'(trap_valid_o), 0);
      tick();
    end
    redirect_ready_i = 1; clr_wb();
    #1;
    chk("bp.hs.rv", 32'(redirect_valid_o), 1);
    chk("bp.hs.fl", 32'(flush_o), 1);
    tick();
    chk("bp.post.rv", 32'(redirect_valid_o), 0);
    chk("bp.post.fl", 32'(flush_o), 0);
    chk("bp.post.tv", 32'(trap_valid_o), 0);
    chk("bp.post.mc", 32'(trap_mcause_o), 4);

    // Handler address sampled after settle, low bits cleared.
    trap_handler_addr_i = 32'h1003;
    exc_evt(32'h700, 31'd3, 32'h0);
    tick(); clr_wb();
    trap_handler_addr_i = 32'h2003;
    tick(); tick();
    chk("align.rpc", redirect_pc_o, 32'h2000);
    chk("align.rv", 32'(redirect_valid_o), 1);
    tick();

    // Async reset while in REDIRECT.
    redirect_ready_i = 0;
    exc_evt(32'h800, 31'd6, 32'h9);
    tick(); clr_wb(); tick(); tick();
    chk("pre_rst.rv", 32'(redirect_valid_o), 1);
    #2 rst_i = 1;
    #1;
    chk_zero("arst");
    tick();
    rst_i = 0;
    redirect_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("idle.rv%0d", i), 32'(redirect_valid_o), 0);
      chk($sformatf("idle.fl%0d", i), 32'(flush_o), 0);
      chk($sformatf("idle.tv%0d", i), 32'(trap_valid_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer that drives the trap-capture interface of the CSR file and consumes its outputs. It detects trap and `mret` events at the write-back boundary and selects between exception and interrupt. It emits a one-cycle trap record for the CSR file to latch into mepc/mcause, flushes the pipeline, and waits for the CSR-side handler address to settle. It then issues a held fetch redirect to `trap_handler_addr` (trap) or `mepc` (`mret`).

## Interface
- SETTLE_CYCLES, 2, cycles waited after a trap/mret pulse before redirecting; covers mtvec→handler register latency and mepc write latency; legal 1..15
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- wb_valid_i  input  1  instruction in WB is valid
- wb_pc_i  input  32  PC of WB instruction
- wb_exc_valid_i  input  1  WB instruction raised a synchronous exception
- wb_exc_cause_i  input  31  exception cause code
- wb_exc_tval_i  input  32  exception trap value
- wb_mret_i  input  1  WB instruction is `mret`
- irq_i  input  1  external interrupt request, level
- irq_en_i  input  1  global machine interrupt enable
- trap_handler_addr_i  input  32  registered handler address from CSR file
- mepc_i  input  32  current mepc from CSR file
- redirect_ready_i  input  1  fetch accepts redirect
- trap_valid_o  output  1  one-cycle trap record strobe to CSR file
- trap_is_interrupt_o  output  1  record is an interrupt
- trap_mcause_o  output  31  record cause
- trap_pc_o  output  32  record PC (→ mepc)
- trap_tval_o  output  32  record tval (→ mtval)
- wb_kill_o  output  1  suppress retirement of the WB instruction this cycle (combinational)
- flush_o  output  1  flush IF..MEM and hold WB invalid
- redirect_valid_o  output  1  redirect request
- redirect_pc_o  output  32  redirect target

## Operation
- States: IDLE, SETTLE, REDIRECT.
- IDLE: an event is recognised only when `wb_valid_i` is high. Priority: interrupt (`irq_i && irq_en_i`) > exception (`wb_exc_valid_i`) > `mret` (`wb_mret_i`).
  - Interrupt: record {is_interrupt=1, mcause=11, pc=wb_pc_i, tval=0}. `wb_kill_o`=1; the WB instruction is not retired and re-executes after return.
  - Exception: record {0, wb_exc_cause_i, wb_pc_i, wb_exc_tval_i}. `wb_kill_o`=1.
  - `mret`: no record, `wb_kill_o`=0 (it retires). Latch target kind = MEPC.
  - On any event: load the settle counter with SETTLE_CYCLES, latch target kind (TRAP/MEPC), go to SETTLE.
- Trap record outputs are registered. `trap_valid_o` is high exactly the cycle after detection. Record fields hold their values until the next record.
- SETTLE: decrement the counter each cycle. When it reaches 0, sample the target (`trap_handler_addr_i & 32'hffff_fffc` or `mepc_i`) into `redirect_pc_o`, assert `redirect_valid_o`, and go to REDIRECT.
- REDIRECT: hold `redirect_valid_o` and `redirect_pc_o` stable until `redirect_ready_i`. On the handshake cycle, return to IDLE.
- `flush_o`: high from the cycle after detection through the handshake cycle inclusive.
- All WB inputs are ignored outside IDLE; the pipeline is being flushed. `irq_i` is level-sensitive, so an interrupt raised during SETTLE/REDIRECT is taken on the first valid WB in IDLE.
- Simultaneous `wb_exc_valid_i` and `wb_mret_i`: exception wins.
- An exception whose cause code exceeds 31 bits is impossible by width; no checking.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, trap_valid_o=0, trap_is_interrupt_o=0, trap_mcause_o=0, trap_pc_o=0, trap_tval_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0. Reset mid-sequence drops any pending redirect.
- Detection at cycle N:
  - trap_valid_o at N+1.
  - SETTLE spans N+1..N+SETTLE_CYCLES.
  - redirect_valid_o first high at N+SETTLE_CYCLES+1.
  - Minimum event-to-refetch latency is SETTLE_CYCLES+1 cycles with ready held high.
- `wb_kill_o` is combinational in cycle N only.
- A new event can be detected in the cycle after the handshake at the earliest.

## Test plan
- Exception: wb_valid=1, exc cause=2, pc=0x100, tval=0xDEAD, handler=0x8000_0004, ready=1 -> wb_kill at N. At N+1: trap_valid with mcause=2, pc=0x100, tval=0xDEAD. At N+3: redirect_pc=0x8000_0004, single-cycle valid. flush high N+1..N+3.
- Interrupt vs exception: irq=1, irq_en=1, and exc in the same cycle -> is_interrupt=1, mcause=11, tval=0. With irq_en=0, the exception record is emitted instead.
- `mret`: mepc_i=0x200 -> no trap_valid, wb_kill=0, redirect_pc=0x200 at N+3.
- Backpressure: ready low for 4 cycles after valid rises -> valid and pc stable for all 4, handshake on cycle 5, flush deasserts after it. An exception presented on WB during the wait is ignored.
- Handler alignment and settle: handler_addr=0x1003 changes to 0x2003 at N+1 -> redirect_pc=0x2000.
- Async reset asserted in REDIRECT -> all outputs 0 immediately. After release, with no event, the block idles.
